// File: rtl/usb_tx_bit_scheduler.sv
// usb_tx_bit_scheduler
// Sequences one USB TX packet (SYNC, DATA bytes, EOP) on a bit-period
// timebase. It drives the shift strobe, the byte-load handshake and the
// bit-stuff slots for the TX shift register and the NRZI/stuff encoder.
// Optional feature macro: TX_ABORT_EN (abort input forces EOP).
module usb_tx_bit_scheduler #(
    parameter int CLKS_PER_BIT = 8,
    parameter int TMR_W        = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tx_start,
    input  logic       byte_valid,
    input  logic       last_byte,
    input  logic       stuff_req,
    input  logic       abort,
    output logic       bit_tick,
    output logic       shift_strobe,
    output logic       load_byte,
    output logic       sync_active,
    output logic       stuff_slot,
    output logic       eop_se0,
    output logic [2:0] bit_index,
    output logic       tx_busy,
    output logic       underrun,
    output logic       tx_done
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SYNC,
        S_DATA,
        S_EOP
    } state_t;

    localparam logic [TMR_W-1:0] TMR_ONE = TMR_W'(1);
    localparam logic [TMR_W-1:0] TMR_MAX = TMR_W'(CLKS_PER_BIT);

    state_t           state;
    state_t           state_n;
    logic [TMR_W-1:0] timer;
    logic [TMR_W-1:0] timer_n;
    logic [2:0]       cnt;          // period counter for SYNC (0..7) and EOP (0..2)
    logic [2:0]       cnt_n;
    logic [2:0]       bit_idx_n;
    logic             last_q;
    logic             last_n;
    logic             stuff_n;
    logic             load_n;
    logic             underrun_n;
    logic             done_n;
    logic             shift_c;
    logic             abort_eff;

    // End of each bit period; never asserted in IDLE because the timer is parked at 1
    assign bit_tick     = (state != S_IDLE) && (timer == TMR_MAX);
    assign shift_strobe = shift_c;

`ifdef TX_ABORT_EN
    logic abort_pend;

    // Remember an abort seen mid-period so it takes effect on the coming tick
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            abort_pend <= 1'b0;
        end else if ((state == S_SYNC) || (state == S_DATA)) begin
            if (bit_tick) begin
                abort_pend <= 1'b0;
            end else if (abort) begin
                abort_pend <= 1'b1;
            end
        end else begin
            abort_pend <= 1'b0;
        end
    end

    assign abort_eff = (abort || abort_pend) && ((state == S_SYNC) || (state == S_DATA));
`else
    logic abort_unused;

    assign abort_unused = abort;
    assign abort_eff    = 1'b0;
`endif

    // State, timer, counters and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= S_IDLE;
            timer       <= TMR_ONE;
            cnt         <= '0;
            bit_index   <= '0;
            last_q      <= 1'b0;
            stuff_slot  <= 1'b0;
            load_byte   <= 1'b0;
            underrun    <= 1'b0;
            tx_done     <= 1'b0;
            sync_active <= 1'b0;
            eop_se0     <= 1'b0;
            tx_busy     <= 1'b0;
        end else begin
            state       <= state_n;
            timer       <= timer_n;
            cnt         <= cnt_n;
            bit_index   <= bit_idx_n;
            last_q      <= last_n;
            stuff_slot  <= stuff_n;
            load_byte   <= load_n;
            underrun    <= underrun_n;
            tx_done     <= done_n;
            sync_active <= (state_n == S_SYNC);
            eop_se0     <= (state_n == S_EOP) && (cnt_n != 3'd2);
            tx_busy     <= (state_n != S_IDLE);
        end
    end

    // Next-state, per-tick decisions and the decoded shift strobe
    always_comb begin
        state_n    = state;
        timer_n    = timer;
        cnt_n      = cnt;
        bit_idx_n  = bit_index;
        last_n     = last_q;
        stuff_n    = stuff_slot;
        load_n     = 1'b0;
        underrun_n = 1'b0;
        done_n     = 1'b0;
        shift_c    = 1'b0;

        if (state == S_IDLE) begin
            timer_n = TMR_ONE;
        end else if (timer == TMR_MAX) begin
            timer_n = TMR_ONE;
        end else begin
            timer_n = timer + TMR_ONE;
        end

        case (state)
            S_IDLE: begin
                // tx_done is still high in the first IDLE cycle, which blocks a restart there
                if (tx_start && !tx_done) begin
                    state_n   = S_SYNC;
                    cnt_n     = '0;
                    bit_idx_n = '0;
                    stuff_n   = 1'b0;
                end
            end

            S_SYNC: begin
                if (bit_tick) begin
                    if (abort_eff) begin
                        state_n   = S_EOP;
                        cnt_n     = '0;
                        bit_idx_n = '0;
                    end else if (cnt != 3'd7) begin
                        shift_c = 1'b1;
                        cnt_n   = cnt + 3'd1;
                    end else if (byte_valid) begin
                        load_n    = 1'b1;
                        last_n    = last_byte;
                        bit_idx_n = '0;
                        state_n   = S_DATA;
                    end else begin
                        underrun_n = 1'b1;
                        state_n    = S_EOP;
                        cnt_n      = '0;
                        bit_idx_n  = '0;
                    end
                end
            end

            S_DATA: begin
                if (bit_tick) begin
                    stuff_n = 1'b0;
                    // A stuff request is honoured before the byte-end decision, so a
                    // stuff bit after bit 7 is sent before the next load or EOP
                    if (abort_eff) begin
                        state_n   = S_EOP;
                        cnt_n     = '0;
                        bit_idx_n = '0;
                    end else if (!stuff_slot && stuff_req) begin
                        stuff_n = 1'b1;
                    end else if (bit_index != 3'd7) begin
                        shift_c   = 1'b1;
                        bit_idx_n = bit_index + 3'd1;
                    end else if (last_q) begin
                        state_n   = S_EOP;
                        cnt_n     = '0;
                        bit_idx_n = '0;
                    end else if (byte_valid) begin
                        load_n    = 1'b1;
                        last_n    = last_byte;
                        bit_idx_n = '0;
                    end else begin
                        underrun_n = 1'b1;
                        state_n    = S_EOP;
                        cnt_n      = '0;
                        bit_idx_n  = '0;
                    end
                end
            end

            S_EOP: begin
                if (bit_tick) begin
                    if (cnt == 3'd2) begin
                        done_n  = 1'b1;
                        state_n = S_IDLE;
                        cnt_n   = '0;
                    end else begin
                        cnt_n = cnt + 3'd1;
                    end
                end
            end

            default: begin
                state_n = S_IDLE;
            end
        endcase
    end

endmodule
